// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath: walks lw, sw, R-type, beq, bne,
// addi, andi, ori and j through fetch/decode/execute/memory/writeback with a timed memory handshake.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic       imm_ext,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQEX  = 4'd8,
    BNEEX  = 4'd9,
    ADDIEX = 4'd10,
    ANDIEX = 4'd11,
    ORIEX  = 4'd12,
    IWB    = 4'd13,
    JEX    = 4'd14,
    FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       imm_ext;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       fault;
  } ctrl_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic             wait_state;
  logic             timed_out;
  ctrl_t            ctrl, ctrl_out;

  assign wait_state = state inside {FETCH, MEMRD, MEMWR};
  // mem_ready in the timeout cycle completes the access, so it masks the fault.
  assign timed_out  = (TIMEOUT_CYCLES != 0) && wait_state && !mem_ready
                      && (wait_cnt == TIMEOUT_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      FETCH: begin
        if (mem_ready)      state_d = DECODE;
        else if (timed_out) state_d = FAULT;
      end
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTEX;
          OP_BEQ:       state_d = BEQEX;
          OP_BNE:       state_d = BNEEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_ORI:       state_d = ORIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FAULT;
        endcase
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)      state_d = MEMWB;
        else if (timed_out) state_d = FAULT;
      end
      MEMWR: begin
        if (mem_ready)      state_d = FETCH;
        else if (timed_out) state_d = FAULT;
      end
      RTEX:                         state_d = RTWB;
      ADDIEX, ANDIEX, ORIEX:        state_d = IWB;
      MEMWB, RTWB, IWB:             state_d = FETCH;
      BEQEX, BNEEX, JEX:            state_d = FETCH;
      FAULT:                        state_d = FAULT;
      default:                      state_d = FAULT;
    endcase
  end

  // Each memory wait starts from zero; stalled cycles count up and hold at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt;
    if ((state_d != state) && (state_d inside {FETCH, MEMRD, MEMWR})) begin
      wait_cnt_d = '0;
    end else if (wait_state && !mem_ready && (wait_cnt != TIMEOUT_CNT)) begin
      wait_cnt_d = wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = mem_ready;
        ctrl.pcen    = mem_ready;
      end
      DECODE: ctrl.alusrcb = 2'b11;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      RTEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 3'b010;
      end
      RTWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BEQEX, BNEEX: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = 3'b001;
        ctrl.pcsrc      = 2'b01;
        ctrl.pcen       = (state == BEQEX) ? zero : ~zero;
        ctrl.instr_done = 1'b1;
      end
      ADDIEX, ANDIEX, ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.imm_ext = (state != ADDIEX);
        ctrl.aluop   = (state == ANDIEX) ? 3'b100 :
                       (state == ORIEX)  ? 3'b011 : 3'b000;
      end
      IWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc      = 2'b10;
        ctrl.pcen       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      FAULT:   ctrl.fault = 1'b1;
      default: ctrl.fault = 1'b1;
    endcase
  end

  // Reset gates the outputs combinationally so an aborted access drops its strobes at once.
  assign ctrl_out   = reset_n ? ctrl : '0;
  assign state_o    = reset_n ? state : 4'd0;

  assign mem_req    = ctrl_out.mem_req;
  assign iord       = ctrl_out.iord;
  assign memwrite   = ctrl_out.memwrite;
  assign irwrite    = ctrl_out.irwrite;
  assign pcen       = ctrl_out.pcen;
  assign pcsrc      = ctrl_out.pcsrc;
  assign alusrca    = ctrl_out.alusrca;
  assign alusrcb    = ctrl_out.alusrcb;
  assign aluop      = ctrl_out.aluop;
  assign imm_ext    = ctrl_out.imm_ext;
  assign regdst     = ctrl_out.regdst;
  assign memtoreg   = ctrl_out.memtoreg;
  assign regwrite   = ctrl_out.regwrite;
  assign instr_done = ctrl_out.instr_done;
  assign fault      = ctrl_out.fault;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM controller that sequences the multicycle MIPS datapath. The datapath has a shared instruction/data memory, an IR, and A/B/ALUOut registers. The controller decodes the IR opcode (op) and walks each instruction through fetch/decode/execute/memory/writeback. Supported instructions: lw, sw, R-type, beq, bne, addi, andi, ori, j. The memory port uses a req/ready handshake with a timeout fault. The block sits between the IR opcode field and the datapath mux/enable controls; the ALU decoder consumes aluop.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ready in any memory state before FAULT; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], stable from DECODE until return to FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
iord  out  1  address select: 0=PC, 1=ALUOut
memwrite  out  1  write strobe, valid while mem_req=1
irwrite  out  1  load IR
pcen  out  1  PC load enable (branch condition already folded in)
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
alusrca  out  1  0=PC, 1=A
alusrcb  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
aluop  out  3  000 add, 001 sub, 010 funct, 011 or, 100 and
imm_ext  out  1  0=sign-extend, 1=zero-extend
regdst  out  1  0=rt, 1=rd
memtoreg  out  1  0=ALUOut, 1=memory data
regwrite  out  1  register file write
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
fault  out  1  sticky illegal-op/timeout flag
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: state=FETCH (0), wait counter=0, fault=0. While reset_n=0 all outputs are forced to 0. Reset mid-instruction aborts it immediately; no write completes.
- Outputs decode from the state only, except pcen/irwrite/instr_done, which are qualified by zero or mem_ready as listed. Unlisted outputs are 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, BNEEX 9, ADDIEX 10, ANDIEX 11, ORIEX 12, IWB 13, JEX 14, FAULT 15.
- FETCH: mem_req=1, iord=0, alusrcb=01, aluop=000, pcsrc=00. irwrite=pcen=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: alusrcb=11, aluop=000 (branch target into ALUOut). Next state by op:
  100011 or 101011 → MEMADR; 000000 → RTEX; 000100 → BEQEX; 000101 → BNEEX; 001000 → ADDIEX; 001100 → ANDIEX; 001101 → ORIEX; 000010 → JEX; any other op → FAULT.
- MEMADR: alusrca=1, alusrcb=10, imm_ext=0, aluop=000. op=100011 → MEMRD; otherwise → MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_ready → MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1 → FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. On mem_ready: instr_done=1 → FETCH.
- RTEX: alusrca=1, alusrcb=00, aluop=010 → RTWB.
- RTWB: regwrite=1, regdst=1, instr_done=1 → FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, pcen=zero, instr_done=1 → FETCH.
- BNEEX: same as BEQEX except pcen=~zero.
- ADDIEX: aluop=000, imm_ext=0. ANDIEX: aluop=100, imm_ext=1. ORIEX: aluop=011, imm_ext=1. All three use alusrca=1, alusrcb=10, then → IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1 → FETCH.
- JEX: pcsrc=10, pcen=1, instr_done=1 → FETCH.
- Wait counter:
  - Cleared on every transition into FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in those states with mem_ready=0, saturating at TIMEOUT_CYCLES.
  - If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES with mem_ready=0 → FAULT.
  - mem_ready in the same cycle as the timeout wins: the access completes.
- FAULT: fault=1, mem_req and all write enables 0. Sticky; only reset exits.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- CPI: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3, each plus memory wait cycles.

Test Plan:
- lw, zero-wait memory (mem_ready=1 always): states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in cycle 5. instr_done pulses once.
- sw with mem_ready delayed 3 cycles in MEMWR: memwrite=1 held for 4 cycles, state stays 5, returns to 0 on the ready cycle. The wait counter does not fault.
- beq with zero=1 → pcen=1, pcsrc=01 in BEQEX. bne with zero=1 → pcen=0. bne with zero=0 → pcen=1.
- andi (op=001100) → ANDIEX shows aluop=100, imm_ext=1, then IWB with regwrite=1, regdst=0. ori shows aluop=011. addi shows aluop=000, imm_ext=0.
- Illegal op=111111 at DECODE → FAULT next cycle, fault=1 held for 20 cycles. reset_n low for 1 cycle → state=0, fault=0.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → FAULT after cycle 5. Second run: mem_ready=1 coincident with count=4 → DECODE, no fault. Async reset asserted mid-MEMWR → memwrite=0 immediately, with no clock edge needed.
